// File: rtl/sata_oob_detector.sv
// Serial ATA OOB receive detector. It conditions rxsignaldetect, measures the
// burst and gap run lengths, and classifies complete sequences as COMINIT or
// COMWAKE.
module sata_oob_detector #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER      = 2,
    parameter int unsigned BURST_MIN   = 14,
    parameter int unsigned BURST_MAX   = 18,
    parameter int unsigned GAPINIT_MIN = 46,
    parameter int unsigned GAPINIT_MAX = 50,
    parameter int unsigned GAPWAKE_MIN = 14,
    parameter int unsigned GAPWAKE_MAX = 18,
    parameter int unsigned BURSTS      = 6,
    parameter int unsigned OOBFIN      = 90
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          rxsignaldetect,
    output logic                          cominit,
    output logic                          comwake,
    output logic                          oob_err,
    output logic                          oobfinish,
    output logic [$clog2(BURSTS+1)-1:0]   burst_num
);
    localparam int unsigned MAX_BG  = (GAPINIT_MAX > BURST_MAX) ? GAPINIT_MAX : BURST_MAX;
    localparam int unsigned RUN_SAT = ((MAX_BG > OOBFIN) ? MAX_BG : OOBFIN) + 1;
    localparam int unsigned RUN_W   = $clog2(RUN_SAT + 1);
    localparam int unsigned CNT_W   = $clog2(BURSTS + 1);
    localparam int unsigned FLT_W   = (FILTER > 1) ? $clog2(FILTER) : 1;

    localparam logic [RUN_W-1:0] RUN_SAT_V = RUN_W'(RUN_SAT);
    localparam logic [RUN_W-1:0] BMIN_V    = RUN_W'(BURST_MIN);
    localparam logic [RUN_W-1:0] BMAX_V    = RUN_W'(BURST_MAX);
    localparam logic [RUN_W-1:0] IMIN_V    = RUN_W'(GAPINIT_MIN);
    localparam logic [RUN_W-1:0] IMAX_V    = RUN_W'(GAPINIT_MAX);
    localparam logic [RUN_W-1:0] WMIN_V    = RUN_W'(GAPWAKE_MIN);
    localparam logic [RUN_W-1:0] WMAX_V    = RUN_W'(GAPWAKE_MAX);
    localparam logic [RUN_W-1:0] GTO_V     = RUN_W'(GAPINIT_MAX + 1);
    localparam logic [RUN_W-1:0] BTO_V     = RUN_W'(BURST_MAX + 1);
    localparam logic [RUN_W-1:0] FIN_V     = RUN_W'(OOBFIN);
    localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FILTER - 1);
    localparam logic [CNT_W-1:0] BURSTS_V  = CNT_W'(BURSTS);

    typedef enum logic [1:0] {StIdle, StGap, StBurst} state_t;
    typedef enum logic [1:0] {KindNone, KindInit, KindWake} kind_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   sigdet_q, sigdet_d, prev_q;
    logic [FLT_W-1:0]       flt_cnt_q, flt_cnt_d;
    logic [RUN_W-1:0]       run_q, run_d, len_q;
    logic                   oobfinish_q;
    logic                   rise, fall;
    logic                   burst_ok, in_init, in_wake;

    state_t                 state_q, state_d;
    kind_t                  kind_q, kind_d;
    logic [CNT_W-1:0]       count_q, count_d, count_inc;
    logic                   cominit_q, cominit_d, comwake_q, comwake_d, err_q, err_d;
    logic                   abort;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    // run_q counts the current level including this cycle, so on an edge
    // cycle len_q (last cycle's run_q) is the length of the finished level.
    assign rise      = sigdet_q & ~prev_q;
    assign fall      = ~sigdet_q & prev_q;
    assign burst_ok  = (len_q >= BMIN_V) && (len_q <= BMAX_V);
    assign in_init   = (len_q >= IMIN_V) && (len_q <= IMAX_V);
    assign in_wake   = (len_q >= WMIN_V) && (len_q <= WMAX_V);
    assign count_inc = count_q + 1'b1;

    // Synchroniser chain for the asynchronous squelch input.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rxsignaldetect};
    end

    // Glitch filter and run-length counter next state.
    always_comb begin
        sigdet_d  = sigdet_q;
        flt_cnt_d = '0;
        if (sync_out != sigdet_q) begin
            if (flt_cnt_q == FLT_LAST) sigdet_d = sync_out;
            else                       flt_cnt_d = flt_cnt_q + 1'b1;
        end
        if (sigdet_d != sigdet_q)  run_d = RUN_W'(1);
        else if (run_q == RUN_SAT_V) run_d = run_q;
        else                       run_d = run_q + 1'b1;
    end

    // Conditioning registers: filtered level, edge history, run lengths.
    always_ff @(posedge clk) begin
        if (reset) begin
            sigdet_q    <= 1'b0;
            prev_q      <= 1'b0;
            flt_cnt_q   <= '0;
            run_q       <= '0;
            len_q       <= '0;
            oobfinish_q <= 1'b0;
        end else begin
            sigdet_q    <= sigdet_d;
            prev_q      <= sigdet_q;
            flt_cnt_q   <= flt_cnt_d;
            run_q       <= run_d;
            len_q       <= run_q;
            oobfinish_q <= sigdet_q && (run_q >= FIN_V);
        end
    end

    // Sequence FSM: next state, burst count, kind lock and pulse requests.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        count_d   = count_q;
        cominit_d = 1'b0;
        comwake_d = 1'b0;
        err_d     = 1'b0;
        abort     = 1'b0;
        if (!en) begin
            state_d = StIdle;
            kind_d  = KindNone;
            count_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    kind_d  = KindNone;
                    count_d = '0;
                    if (fall && burst_ok) begin
                        count_d = CNT_W'(1);
                        state_d = StGap;
                    end
                end
                StGap: begin
                    if (rise) begin
                        if (in_init && kind_q != KindWake) begin
                            kind_d  = KindInit;
                            state_d = StBurst;
                        end else if (in_wake && kind_q != KindInit) begin
                            kind_d  = KindWake;
                            state_d = StBurst;
                        end else begin
                            abort = 1'b1;
                        end
                    end else if (run_q >= GTO_V) begin
                        abort = 1'b1;
                    end
                end
                StBurst: begin
                    if (fall) begin
                        if (!burst_ok) begin
                            abort = 1'b1;
                        end else if (count_inc == BURSTS_V) begin
                            cominit_d = (kind_q == KindInit);
                            comwake_d = (kind_q == KindWake);
                            state_d   = StIdle;
                            kind_d    = KindNone;
                            count_d   = '0;
                        end else begin
                            count_d = count_inc;
                            state_d = StGap;
                        end
                    end else if (run_q >= BTO_V) begin
                        abort = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (abort) begin
                err_d   = 1'b1;
                state_d = StIdle;
                kind_d  = KindNone;
                count_d = '0;
            end
        end
    end

    // FSM state and registered output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            kind_q    <= KindNone;
            count_q   <= '0;
            cominit_q <= 1'b0;
            comwake_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            count_q   <= count_d;
            cominit_q <= cominit_d;
            comwake_q <= comwake_d;
            err_q     <= err_d;
        end
    end

    assign cominit   = cominit_q;
    assign comwake   = comwake_q;
    assign oob_err   = err_q;
    assign oobfinish = oobfinish_q;
    assign burst_num = count_q;

endmodule
